multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/riscv_pkg.sv | 79 +++++++
 rtl/opcode_class_decode.sv | 25 ++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states, operand/writeback/next-PC selects.
package riscv_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StTrap
  } state_e;

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    PcPlus4    = 2'd0,
    PcPlusImm  = 2'd1,
    PcAluAlign = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    WbAlu = 2'd0,
    WbMem = 2'd1,
    WbPc4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    SrcARs1  = 2'd0,
    SrcAPc   = 2'd1,
    SrcAZero = 2'd2
  } alu_src_a_e;

  typedef enum logic [1:0] {
    AluAdd    = 2'd0,
    AluBranch = 2'd1,
    AluFunct  = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    ClsR,
    ClsOpImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc,
    ClsIllegal
  } op_class_e;

  // R-type has no immediate; it shares the I encoding (0) with illegal opcodes.
  function automatic imm_sel_e imm_sel_for(op_class_e cls);
    case (cls)
      ClsStore:        return ImmS;
      ClsBranch:       return ImmB;
      ClsLui, ClsAuipc: return ImmU;
      ClsJal:          return ImmJ;
      default:         return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational map from the 7-bit major opcode to an instruction class.
module opcode_class_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = ClsIllegal;
    case (opcode)
      OpcR:      op_class = ClsR;
      OpcOpImm:  op_class = ClsOpImm;
      OpcLoad:   op_class = ClsLoad;
      OpcStore:  op_class = ClsStore;
      OpcBranch: op_class = ClsBranch;
      OpcJal:    op_class = ClsJal;
      OpcJalr:   op_class = ClsJalr;
      OpcLui:    op_class = ClsLui;
      OpcAuipc:  op_class = ClsAuipc;
      default:   op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// sticky illegal-opcode trap and retired-instruction counter.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int unsigned RET_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_re,
  output logic             ir_write,
  output logic [2:0]       imm_sel,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [RET_W-1:0] retired
);

  localparam logic [RET_W-1:0] RetOne = RET_W'(1);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q;
  logic             illegal_q, illegal_d;
  logic             active_q;
  logic [RET_W-1:0] retired_q;
  op_class_e        op_class;

  logic unused_inst;
  assign unused_inst = ^inst[31:7];

  opcode_class_decode u_decode (
    .opcode   (opcode_q),
    .op_class (op_class)
  );

  // active_q keeps every output quiet until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      active_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      active_q  <= 1'b1;
      if (ir_write) opcode_q <= inst[6:0];
      if (pc_write) retired_q <= retired_q + RetOne;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    imem_re   = 1'b0;
    ir_write  = 1'b0;
    imm_sel   = '0;
    alu_src_a = '0;
    alu_src_b = 1'b0;
    alu_op    = '0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = '0;
    pc_write  = 1'b0;
    pc_src    = '0;

    if (active_q) begin
      case (state_q)
        StFetch: begin
          imem_re  = 1'b1;
          ir_write = imem_ready;
          if (imem_ready) state_d = StDecode;
        end

        StDecode: begin
          imm_sel = imm_sel_for(op_class);
          if (op_class == ClsIllegal) begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end else begin
            state_d = StExecute;
          end
        end

        StExecute: begin
          imm_sel = imm_sel_for(op_class);
          state_d = StWriteback;
          case (op_class)
            ClsR: alu_op = AluFunct;
            ClsOpImm: begin
              alu_src_b = 1'b1;
              alu_op    = AluFunct;
            end
            ClsLoad, ClsStore: begin
              alu_src_b = 1'b1;
              state_d   = StMem;
            end
            ClsJalr: alu_src_b = 1'b1;
            ClsLui: begin
              alu_src_a = SrcAZero;
              alu_src_b = 1'b1;
            end
            ClsAuipc: begin
              alu_src_a = SrcAPc;
              alu_src_b = 1'b1;
            end
            ClsBranch: begin
              alu_op   = AluBranch;
              pc_write = 1'b1;
              pc_src   = branch_taken ? PcPlusImm : PcPlus4;
              state_d  = StFetch;
            end
            default: ;
          endcase
        end

        StMem: begin
          imm_sel = imm_sel_for(op_class);
          if (op_class == ClsLoad) begin
            dmem_re = 1'b1;
            if (dmem_ready) state_d = StWriteback;
          end else begin
            dmem_we = 1'b1;
            if (dmem_ready) begin
              pc_write = 1'b1;
              pc_src   = PcPlus4;
              state_d  = StFetch;
            end
          end
        end

        StWriteback: begin
          imm_sel   = imm_sel_for(op_class);
          reg_write = 1'b1;
          pc_write  = 1'b1;
          state_d   = StFetch;
          case (op_class)
            ClsLoad:         wb_sel = WbMem;
            ClsJal, ClsJalr: wb_sel = WbPc4;
            default:         wb_sel = WbAlu;
          endcase
          case (op_class)
            ClsJal:  pc_src = PcPlusImm;
            ClsJalr: pc_src = PcAluAlign;
            default: pc_src = PcPlus4;
          endcase
        end

        StTrap: ;

        default: state_d = StFetch;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors against hand-computed values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        imem_ready, dmem_ready, branch_taken;

  logic       imem_re, ir_write, alu_src_b, dmem_re, dmem_we, reg_write, pc_write, illegal;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a, alu_op, wb_sel, pc_src;
  logic [3:0] retired;

  logic        w_imem_re, w_ir_write, w_alu_src_b, w_dmem_re, w_dmem_we, w_reg_write;
  logic        w_pc_write, w_illegal;
  logic [2:0]  w_imm_sel;
  logic [1:0]  w_alu_src_a, w_alu_op, w_wb_sel, w_pc_src;
  logic [31:0] w_retired;

  logic [18:0] obs;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.RET_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .imem_re      (imem_re),
    .ir_write     (ir_write),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .illegal      (illegal),
    .retired      (retired)
  );

  multicycle_control dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst         (inst),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .imem_re      (w_imem_re),
    .ir_write     (w_ir_write),
    .imm_sel      (w_imm_sel),
    .alu_src_a    (w_alu_src_a),
    .alu_src_b    (w_alu_src_b),
    .alu_op       (w_alu_op),
    .dmem_re      (w_dmem_re),
    .dmem_we      (w_dmem_we),
    .reg_write    (w_reg_write),
    .wb_sel       (w_wb_sel),
    .pc_write     (w_pc_write),
    .pc_src       (w_pc_src),
    .illegal      (w_illegal),
    .retired      (w_retired)
  );

  assign obs = {imem_re, ir_write, imm_sel, alu_src_a, alu_src_b, alu_op,
                dmem_re, dmem_we, reg_write, wb_sel, pc_write, pc_src, illegal};

  function automatic logic [18:0] ov(int re, int irw, int imm, int a, int b, int op, int dre,
                                     int dwe, int rw, int wb, int pw, int ps, int ill);
    return {re[0], irw[0], imm[2:0], a[1:0], b[0], op[1:0], dre[0], dwe[0], rw[0], wb[1:0],
            pw[0], ps[1:0], ill[0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive inputs for one cycle, compare the output vector mid-cycle, then advance.
  task automatic cyc(input string tag, input logic ir, input logic dr, input logic bt,
                     input logic [18:0] exp);
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    #1;
    check(tag, {45'b0, obs}, {45'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic ir, input logic dr);
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] instr,
                              input logic [18:0] exp_d);
    inst = instr;
    cyc({tag, "_f"}, 1'b1, 1'b0, 1'b0, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc({tag, "_d"}, 1'b0, 1'b0, 1'b0, exp_d);
  endtask

  task automatic check_ret(input string tag, input int exp4, input int exp32);
    check({tag, "_r4"}, {60'b0, retired}, 64'(exp4));
    check({tag, "_r32"}, {32'b0, w_retired}, 64'(exp32));
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    check("rst_outs", {45'b0, obs}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_quiet", {45'b0, obs}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    inst         = 32'h0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {45'b0, obs}, 64'd0);
    check_ret("reset", 0, 0);
    rst_n = 1'b1;
    #1;
    check("release_quiet", {45'b0, obs}, 64'd0);
    @(posedge clk);
    #1;

    // ADD
    inst = 32'h002081B3;
    cyc("f_wait", 1'b0, 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    fetch_decode("add", 32'h002081B3, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    check_ret("add", 1, 1);

    // LW with three wait cycles
    fetch_decode("lw", 32'h0000A103, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("lw_mwait", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc("lw_mdone", 1'b0, 1'b1, 1'b0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc("lw_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    check_ret("lw", 2, 2);

    // BEQ taken / not taken
    fetch_decode("beq_t", 32'h00208463, ov(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_t_e", 1'b0, 1'b0, 1'b1, ov(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    fetch_decode("beq_n", 32'h00208463, ov(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("beq_n_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    check_ret("beq", 4, 4);

    // JALR, JAL
    fetch_decode("jalr", 32'h000080E7, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jalr_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 0));
    fetch_decode("jal", 32'h008000EF, ov(0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("jal_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 4, 0, 0, 0, 0, 0, 1, 2, 1, 1, 0));

    // SW with one wait cycle
    fetch_decode("sw", 32'h0020A023, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("sw_mwait", 1'b0, 1'b0, 1'b0, ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc("sw_mdone", 1'b0, 1'b1, 1'b0, ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));

    // LUI, AUIPC, ADDI
    fetch_decode("lui", 32'h12345037, ov(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lui_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lui_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    fetch_decode("auipc", 32'h00000017, ov(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("auipc_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("auipc_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    fetch_decode("addi", 32'h00100093, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("addi_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    check_ret("seq", 10, 10);

    // Illegal opcode: sticky trap ignoring inputs
    fetch_decode("ill", 32'h0000007F, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 11; i++)
      cyc("trap", 1'b1, 1'b1, 1'b1, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check_ret("trap", 10, 10);

    // Reset mid-MEM abandons the load
    do_reset();
    fetch_decode("add2", 32'h002081B3, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add2_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    cyc("add2_wb", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    fetch_decode("lw2", 32'h0000A103, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lw2_e", 1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    #1;
    check("lw2_mem", {45'b0, obs}, {45'b0, ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
    check_ret("pre_rst", 1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {45'b0, obs}, 64'd0);
    check_ret("midrst", 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrel_quiet", {45'b0, obs}, 64'd0);
    @(posedge clk);
    #1;
    cyc("post_rst_f", 1'b0, 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // 16 ADDs wrap a 4-bit counter
    inst = 32'h002081B3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      if (i == 14) check_ret("wrap15", 15, 15);
    end
    check_ret("wrap16", 0, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
